// File: rtl/pipe_pkg.sv
// Shared widths, EX/MEM and MEM/WB field offsets and FSM states for the memory-access stage.
package pipe_pkg;

  localparam int unsigned N               = 24;
  localparam int unsigned M               = 6;
  localparam int unsigned LANES_W         = M * N;
  localparam int unsigned SET_VALUES_BUFFER = 17;
  localparam int unsigned BW              = SET_VALUES_BUFFER + 2 * LANES_W;
  localparam int unsigned WBW             = 6 + LANES_W;
  localparam int unsigned CNT_W           = $clog2(M);

  // EX/MEM word layout, LSB upwards: rd3, Rc, regWrite, memToReg, memWrite, flags, aluResult, opCode, opType, modeSel
  localparam int unsigned RD3_HI     = LANES_W - 1;
  localparam int unsigned RC_LO      = LANES_W;
  localparam int unsigned RC_HI      = RC_LO + 3;
  localparam int unsigned REGWRITE_B = RC_HI + 1;
  localparam int unsigned MEMTOREG_B = REGWRITE_B + 1;
  localparam int unsigned MEMWRITE_B = MEMTOREG_B + 1;
  localparam int unsigned ALURES_LO  = MEMWRITE_B + 4;
  localparam int unsigned ALURES_HI  = ALURES_LO + LANES_W - 1;
  localparam int unsigned MODESEL_B  = BW - 1;

  // MEM/WB word layout, LSB upwards: result, Rc, regWrite, modeSel
  localparam int unsigned WB_RES_HI     = LANES_W - 1;
  localparam int unsigned WB_RC_LO      = LANES_W;
  localparam int unsigned WB_RC_HI      = WB_RC_LO + 3;
  localparam int unsigned WB_REGWRITE_B = WB_RC_HI + 1;
  localparam int unsigned WB_MODESEL_B  = WB_REGWRITE_B + 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } beatState_e;

  // Number of memory beats an access needs: one per lane in vector mode.
  function automatic logic [CNT_W-1:0] beatCount(input logic vecMode);
    return vecMode ? CNT_W'(M) : CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Single-port word-wide data-memory bus with a req/ready beat handshake.
interface mem_access_stage_if;
  import pipe_pkg::*;

  logic         memReq;
  logic         memWe;
  logic [N-1:0] memAddr;
  logic [N-1:0] memWdata;
  logic [N-1:0] memRdata;
  logic         memReady;

  modport master (
    output memReq, memWe, memAddr, memWdata,
    input  memRdata, memReady
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata,
    output memRdata, memReady
  );

endinterface

// File: rtl/mem_beat_ctrl.sv
// Beat sequencer: walks the lanes of an access, one beat per accepted handshake, and raises stall until the last beat lands.
module mem_beat_ctrl
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             isMem,
  input  logic             vecMode,
  input  logic             memReady,
  output logic [CNT_W-1:0] beatIdx,
  output logic             lastBeat,
  output logic             beatDone,
  output logic             stall
);

  beatState_e       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state, counter advance and the combinational stall/beat strobes.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    beatIdx   = cnt;
    lastBeat  = (cnt == beatCount(vecMode) - CNT_W'(1));
    beatDone  = isMem & memReady & rst;
    stall     = isMem & rst & ~(lastBeat & memReady);

    if (!isMem) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (memReady && lastBeat) begin
            stateNext = IDLE;
            cntNext   = '0;
          end else if (memReady) begin
            stateNext = ACCESS;
            cntNext   = CNT_W'(1);
          end else begin
            stateNext = ACCESS;
            cntNext   = '0;
          end
        end
        ACCESS: begin
          if (memReady && lastBeat) begin
            stateNext = IDLE;
            cntNext   = '0;
          end else if (memReady) begin
            cntNext = cnt + CNT_W'(1);
          end
        end
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM consumer: unpacks the execute word, serialises the data-memory access into lane beats and fills MEM/WB.
module mem_access_stage
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [BW-1:0]       exMemIn,
  mem_access_stage_if.master  memBus,
  output logic                stall,
  output logic [WBW-1:0]      memWbOut
);

  logic               modeSel, memWrite, memToReg, regWrite, isMem;
  logic [3:0]         rc;
  logic [LANES_W-1:0] aluResult, rd3, loadData, result;
  logic [N-1:0]       base, laneWdata;
  logic [CNT_W-1:0]   beatIdx;
  logic               lastBeat, beatDone;
  logic [(M-1)*N-1:0] gather;
  logic               unusedBits;

  assign modeSel   = exMemIn[MODESEL_B];
  assign aluResult = exMemIn[ALURES_HI:ALURES_LO];
  assign memWrite  = exMemIn[MEMWRITE_B];
  assign memToReg  = exMemIn[MEMTOREG_B];
  assign regWrite  = exMemIn[REGWRITE_B];
  assign rc        = exMemIn[RC_HI:RC_LO];
  assign rd3       = exMemIn[RD3_HI:0];
  assign unusedBits = ^{exMemIn[MODESEL_B-1:ALURES_HI+1], exMemIn[ALURES_LO-1:MEMWRITE_B+1]};

  assign isMem = memWrite | memToReg;
  assign base  = aluResult[N-1:0];

  mem_beat_ctrl uBeatCtrl (
    .clk      (clk),
    .rst      (rst),
    .isMem    (isMem),
    .vecMode  (modeSel),
    .memReady (memBus.memReady),
    .beatIdx  (beatIdx),
    .lastBeat (lastBeat),
    .beatDone (beatDone),
    .stall    (stall)
  );

  // Select the store lane for the current beat.
  always_comb begin
    laneWdata = '0;
    for (int unsigned l = 0; l < M; l++) begin
      if (beatIdx == CNT_W'(l)) laneWdata = rd3[l*N +: N];
    end
  end

  assign memBus.memReq   = isMem & rst;
  assign memBus.memWe    = memWrite & rst;
  assign memBus.memAddr  = base + N'(beatIdx);
  assign memBus.memWdata = laneWdata;

  // Capture every non-final load lane; the final lane bypasses straight into MEM/WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gather <= '0;
    end else if (beatDone && !lastBeat) begin
      for (int unsigned l = 0; l < M - 1; l++) begin
        if (beatIdx == CNT_W'(l)) gather[l*N +: N] <= memBus.memRdata;
      end
    end
  end

  assign loadData = modeSel ? {memBus.memRdata, gather}
                            : {{((M-1)*N){1'b0}}, memBus.memRdata};
  // A simultaneous write and load is a write; the ALU value is forwarded.
  assign result   = (memToReg && !memWrite) ? loadData : aluResult;

  // MEM/WB register: bubble while stalled so a multi-beat access writes back exactly once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memWbOut <= '0;
    end else if (stall) begin
      memWbOut <= '0;
    end else begin
      memWbOut[WB_MODESEL_B]        <= modeSel;
      memWbOut[WB_REGWRITE_B]       <= regWrite;
      memWbOut[WB_RC_HI:WB_RC_LO]   <= rc;
      memWbOut[WB_RES_HI:0]         <= result;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written multi-beat/reset sequences and randomised accesses.
module tb_mem_access_stage;

  localparam int N   = 24;
  localparam int M   = 6;
  localparam int LW  = M * N;
  localparam int BW  = 17 + 2 * LW;
  localparam int WBW = 6 + LW;

  logic           clk;
  logic           rst;
  logic [BW-1:0]  exMemIn;
  logic           stall;
  logic [WBW-1:0] memWbOut;
  logic           readyDrv;
  logic           useModel;
  logic [N-1:0]   rdataDrv;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if memIf();

  mem_access_stage dut (
    .clk      (clk),
    .rst      (rst),
    .exMemIn  (exMemIn),
    .memBus   (memIf),
    .stall    (stall),
    .memWbOut (memWbOut)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [N-1:0] memFn(input logic [N-1:0] a);
    logic [N-1:0] t;
    t = a * 24'd7;
    return t ^ 24'h3C5A96;
  endfunction

  assign memIf.memRdata = useModel ? memFn(memIf.memAddr) : rdataDrv;
  assign memIf.memReady = readyDrv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream must hold the EX/MEM word while stalled.
  logic          prevStall;
  logic [BW-1:0] prevWord;
  always @(posedge clk) begin
    if (rst && prevStall === 1'b1)
      assert (exMemIn == prevWord) else $error("protocol violation: exMemIn changed while stalled");
    prevStall <= stall;
    prevWord  <= exMemIn;
  end

  function automatic logic [BW-1:0] mkWord(input bit ms, mw, mtr, rw, input logic [3:0] rc,
                                           input logic [LW-1:0] alu, rd3);
    return {ms, 2'b01, 4'hA, alu, 1'b0, 1'b1, 1'b0, mw, mtr, rw, rc, rd3};
  endfunction

  task automatic chk(input string nm, input logic [WBW-1:0] act, input logic [WBW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one instruction to completion, checking every beat and the MEM/WB word.
  task automatic runInstr(input bit ms, mw, mtr, rw, input logic [3:0] rc,
                          input logic [LW-1:0] alu, rd3, input int holdBeat, holdCycles,
                          input bit randReady, input string nm);
    bit isMem;
    int beats, beat, waited, cyc;
    bit rdy, expStall, done;
    logic [N-1:0]  base;
    logic [LW-1:0] res;
    isMem  = mw | mtr;
    beats  = ms ? M : 1;
    base   = alu[N-1:0];
    beat   = 0;
    waited = 0;
    cyc    = 0;
    done   = 0;
    if (mtr && !mw) begin
      res = '0;
      for (int i = 0; i < beats; i++) res[i*N +: N] = memFn(N'(base + N'(i)));
    end else begin
      res = alu;
    end
    useModel = 1'b1;
    exMemIn  = mkWord(ms, mw, mtr, rw, rc, alu, rd3);
    while (!done) begin
      rdy = 1'b1;
      if (isMem && beat == holdBeat && waited < holdCycles) begin
        rdy = 1'b0;
        waited++;
      end else if (randReady) begin
        rdy = ($urandom_range(0, 2) != 0);
      end
      readyDrv = rdy;
      #1;
      chk({nm, " req"}, WBW'(memIf.memReq), WBW'(isMem));
      if (isMem) begin
        chk({nm, " addr"}, WBW'(memIf.memAddr), WBW'(N'(base + N'(beat))));
        chk({nm, " we"}, WBW'(memIf.memWe), WBW'(mw));
        if (mw) chk({nm, " wdata"}, WBW'(memIf.memWdata), WBW'(rd3[beat*N +: N]));
      end
      expStall = isMem && !(beat == beats - 1 && rdy);
      chk({nm, " stall"}, WBW'(stall), WBW'(expStall));
      if (isMem && rdy) beat++;
      done = !isMem || beat == beats;
      @(posedge clk);
      #1;
      chk({nm, " memWb"}, memWbOut, done ? {ms, rw, rc, res} : '0);
      cyc++;
      if (!done && cyc > 100) begin
        checks++;
        errors++;
        $display("FAIL %s timeout: beat %0d of %0d after %0d cycles", nm, beat, beats, cyc);
        done = 1;
      end
    end
  endtask

  typedef struct {
    string        name;
    bit           ms, mw, mtr, rw;
    logic [3:0]   rc;
    logic [N-1:0] alu, wd0, rdata;
    bit           expReq, expWe;
    logic [N-1:0] expAddr;
    logic [WBW-1:0] expWb;
  } vec_t;

  vec_t tbl[7];
  logic [LW-1:0] rd3v, aluv;
  logic [3:0]    rcR;
  bit            msR, mwR, mtrR, rwR;
  int            kind;

  initial begin
    tbl[0] = '{"scalar load", 0, 0, 1, 1, 4'd3, 24'h000010, 24'h0, 24'hABCDEF, 1, 0, 24'h000010,
               {1'b0, 1'b1, 4'd3, 120'd0, 24'hABCDEF}};
    tbl[1] = '{"alu op", 0, 0, 0, 1, 4'd7, 24'h000123, 24'h0, 24'h0, 0, 0, 24'h0,
               {1'b0, 1'b1, 4'd7, 120'd0, 24'h000123}};
    tbl[2] = '{"scalar store fwd", 0, 1, 0, 1, 4'd5, 24'h000200, 24'h55AA55, 24'h0, 1, 1, 24'h000200,
               {1'b0, 1'b1, 4'd5, 120'd0, 24'h000200}};
    tbl[3] = '{"write and load", 0, 1, 1, 1, 4'd9, 24'h000300, 24'h111111, 24'h777777, 1, 1, 24'h000300,
               {1'b0, 1'b1, 4'd9, 120'd0, 24'h000300}};
    tbl[4] = '{"load top addr", 0, 0, 1, 1, 4'd15, 24'hFFFFFF, 24'h0, 24'h0F0F0F, 1, 0, 24'hFFFFFF,
               {1'b0, 1'b1, 4'd15, 120'd0, 24'h0F0F0F}};
    tbl[5] = '{"alu no regwrite", 0, 0, 0, 0, 4'd2, 24'hFEDCBA, 24'h0, 24'h0, 0, 0, 24'h0,
               {1'b0, 1'b0, 4'd2, 120'd0, 24'hFEDCBA}};
    tbl[6] = '{"alu vector mode", 1, 0, 0, 1, 4'd4, 24'h00ABCD, 24'h0, 24'h0, 0, 0, 24'h0,
               {1'b1, 1'b1, 4'd4, 120'd0, 24'h00ABCD}};

    // Reset state, with a load already presented.
    rst      = 1'b0;
    readyDrv = 1'b1;
    useModel = 1'b0;
    rdataDrv = 24'h0;
    exMemIn  = mkWord(1, 0, 1, 1, 4'd1, LW'(24'h40), '0);
    #3;
    chk("reset req", WBW'(memIf.memReq), '0);
    chk("reset stall", WBW'(stall), '0);
    chk("reset we", WBW'(memIf.memWe), '0);
    chk("reset memWb", memWbOut, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    exMemIn = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat directed table.
    for (int i = 0; i < 7; i++) begin
      useModel = 1'b0;
      rdataDrv = tbl[i].rdata;
      readyDrv = 1'b1;
      exMemIn  = mkWord(tbl[i].ms, tbl[i].mw, tbl[i].mtr, tbl[i].rw, tbl[i].rc,
                        LW'(tbl[i].alu), LW'(tbl[i].wd0));
      #1;
      chk({tbl[i].name, " req"}, WBW'(memIf.memReq), WBW'(tbl[i].expReq));
      chk({tbl[i].name, " stall"}, WBW'(stall), '0);
      if (tbl[i].expReq) begin
        chk({tbl[i].name, " addr"}, WBW'(memIf.memAddr), WBW'(tbl[i].expAddr));
        chk({tbl[i].name, " we"}, WBW'(memIf.memWe), WBW'(tbl[i].expWe));
      end
      if (tbl[i].expWe) chk({tbl[i].name, " wdata"}, WBW'(memIf.memWdata), WBW'(tbl[i].wd0));
      @(posedge clk);
      #1;
      chk({tbl[i].name, " memWb"}, memWbOut, tbl[i].expWb);
    end

    // Asynchronous reset clears a live MEM/WB word immediately.
    #2;
    rst = 1'b0;
    #1;
    chk("async reset memWb", memWbOut, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Vector store, lanes 1..6 at 0x100.
    for (int i = 0; i < M; i++) rd3v[i*N +: N] = N'(i + 1);
    runInstr(1, 1, 0, 0, 4'd1, LW'(24'h000100), rd3v, -1, 0, 0, "vec store");

    // Vector load with beat 3 held off for two cycles.
    runInstr(1, 0, 1, 1, 4'd6, LW'(24'h000400), '0, 3, 2, 0, "vec load hold");

    // Vector load wrapping through the top of the address space.
    runInstr(1, 0, 1, 1, 4'd8, LW'(24'hFFFFFE), '0, -1, 0, 0, "vec load wrap");

    // Reset during beat 2 of a vector load, then restart from beat 0.
    useModel = 1'b1;
    readyDrv = 1'b1;
    exMemIn  = mkWord(1, 0, 1, 1, 4'd10, LW'(24'h000500), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid-vector addr", WBW'(memIf.memAddr), WBW'(24'h000502));
    chk("mid-vector stall", WBW'(stall), WBW'(1));
    rst = 1'b0;
    #1;
    chk("mid-vector reset req", WBW'(memIf.memReq), '0);
    chk("mid-vector reset stall", WBW'(stall), '0);
    chk("mid-vector reset we", WBW'(memIf.memWe), '0);
    chk("mid-vector reset memWb", memWbOut, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("restart addr", WBW'(memIf.memAddr), WBW'(24'h000500));
    chk("restart req", WBW'(memIf.memReq), WBW'(1));
    runInstr(1, 0, 1, 1, 4'd10, LW'(24'h000500), '0, -1, 0, 0, "vec load restart");

    // Randomised instruction stream with a random-ready memory.
    for (int t = 0; t < 40; t++) begin
      msR  = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      mwR  = (kind == 2 || kind == 3);
      mtrR = (kind == 1 || kind == 3);
      rwR  = 1'($urandom_range(0, 1));
      rcR  = 4'($urandom_range(0, 15));
      for (int i = 0; i < M; i++) begin
        aluv[i*N +: N] = N'($urandom);
        rd3v[i*N +: N] = N'($urandom);
      end
      if ($urandom_range(0, 3) == 0) aluv[N-1:0] = N'(24'hFFFFFC + 24'($urandom_range(0, 3)));
      runInstr(msR, mwR, mtrR, rwR, rcR, aluv, rd3v, -1, 0, 1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
